// File: rtl/cpu_prefetch.sv
// cpu_prefetch: instruction prefetch unit between the CPU core and the shared bus.
// A three-state sequencer (IDLE/ADDR/DATA) issues one read at a time from
// fetch_pc and pushes the returned byte into a DEPTH-entry FIFO that the core
// pops from. flush redirects fetch, hold blocks the start of a new read.
// Optional macro CPU_PREFETCH_PAIR_EN adds q_data1/q_valid2/q_pop2 so the core
// can consume a 16-bit operand in one cycle.
module cpu_prefetch #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 8,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h2000
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] address_bus,
    output logic              r,
    input  logic [DATA_W-1:0] bus_data_in,
    input  logic              hold,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    output logic              q_valid,
    output logic [DATA_W-1:0] q_data,
    output logic [ADDR_W-1:0] q_pc,
    input  logic              q_pop
`ifdef CPU_PREFETCH_PAIR_EN
    ,
    output logic [DATA_W-1:0] q_data1,
    output logic              q_valid2,
    input  logic              q_pop2
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t            state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] head_pc;
    logic [DATA_W-1:0] fifo_mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr_nxt;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nxt;
    logic [CW-1:0]     npop;
    logic [CW-1:0]     remaining;
    logic              push;
    logic              pop1;
    logic              pop2;
    logic [DATA_W-1:0] head_nxt;
`ifdef CPU_PREFETCH_PAIR_EN
    logic [DATA_W-1:0] head1_nxt;
`endif

    assign q_pc = head_pc;

    // Work out this edge's push/pop, the next occupancy and the next head bytes.
    always_comb begin
        // NOTE: every signal gets a value on every path so no latch is inferred.
        push = (state == DATA) && !flush;
        pop1 = q_pop && (count != '0);
`ifdef CPU_PREFETCH_PAIR_EN
        pop2 = q_pop2 && (count >= CW'(2));
`else
        pop2 = 1'b0;
`endif
        npop = '0;
        if (flush)
            npop = '0;
        else if (pop2)
            npop = CW'(2);
        else if (pop1)
            npop = CW'(1);
        count_nxt  = flush ? '0 : count + CW'(push) - npop;
        remaining  = count - npop;
        rd_ptr_nxt = rd_ptr + npop[PW-1:0];
        // A byte landing in an otherwise empty slot becomes the head directly.
        head_nxt   = (push && remaining == '0) ? bus_data_in : fifo_mem[rd_ptr_nxt];
`ifdef CPU_PREFETCH_PAIR_EN
        head1_nxt  = (push && remaining == CW'(1)) ? bus_data_in
                                                   : fifo_mem[rd_ptr_nxt + PW'(1)];
`endif
    end

    // Fetch sequencer: one ADDR/DATA pair per read, registered bus strobe/address.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) begin
            state       <= IDLE;
            r           <= 1'b0;
            address_bus <= '0;
            fetch_pc    <= RESET_PC;
        end else if (flush) begin
            fetch_pc <= flush_pc;
            if (hold) begin
                state       <= IDLE;
                r           <= 1'b0;
                address_bus <= '0;
            end else begin
                state       <= ADDR;
                r           <= 1'b1;
                address_bus <= flush_pc;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (count < DEPTH_C && !hold) begin
                        state       <= ADDR;
                        r           <= 1'b1;
                        address_bus <= fetch_pc;
                    end
                end
                ADDR: begin
                    state       <= DATA;
                    r           <= 1'b0;
                    address_bus <= '0;
                    fetch_pc    <= fetch_pc + ADDR_W'(1);
                end
                DATA: begin
                    if (count_nxt < DEPTH_C && !hold) begin
                        state       <= ADDR;
                        r           <= 1'b1;
                        address_bus <= fetch_pc;
                    end else begin
                        state       <= IDLE;
                        r           <= 1'b0;
                        address_bus <= '0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    r           <= 1'b0;
                    address_bus <= '0;
                end
            endcase
        end
    end

    // FIFO pointers, occupancy and the registered head view seen by the core.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            head_pc  <= RESET_PC;
            q_valid  <= 1'b0;
            q_data   <= '0;
`ifdef CPU_PREFETCH_PAIR_EN
            q_valid2 <= 1'b0;
            q_data1  <= '0;
`endif
        end else if (flush) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            head_pc  <= flush_pc;
            q_valid  <= 1'b0;
`ifdef CPU_PREFETCH_PAIR_EN
            q_valid2 <= 1'b0;
`endif
        end else begin
            count   <= count_nxt;
            rd_ptr  <= rd_ptr_nxt;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            head_pc <= head_pc + ADDR_W'(npop);
            q_valid <= (count_nxt != '0);
            q_data  <= head_nxt;
`ifdef CPU_PREFETCH_PAIR_EN
            q_valid2 <= (count_nxt >= CW'(2));
            q_data1  <= head1_nxt;
`endif
        end
    end

    // Byte storage written at the tail when a read completes.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; count/q_valid decide what is meaningful.
        if (push)
            fifo_mem[wr_ptr] <= bus_data_in;
    end

endmodule

// File: doc/cpu_prefetch.md
# cpu_prefetch

Parametrised instruction-prefetch unit between the CPU core and the shared memory bus. It replaces the core's inline two-cycle byte fetch with a sequencer that issues back-to-back bus reads from an internal fetch pointer and buffers the bytes in a DEPTH-entry FIFO. The core pops opcode and operand bytes from the FIFO, redirects fetch on branch/jump via flush, and can hold off prefetch while it owns the bus for data accesses.

## Interface
- ADDR_W, 16, address and PC width
- DATA_W, 8, bus and queue byte width
- DEPTH, 4, FIFO entries (power of two, ≥2)
- RESET_PC, 16'h2000, fetch start address after reset
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- address_bus  out  ADDR_W  bus read address
- r  out  1  bus read strobe
- bus_data_in  in  DATA_W  read data from memory
- hold  in  1  core owns bus; no new read may start
- flush  in  1  discard queue and in-flight read, redirect fetch
- flush_pc  in  ADDR_W  new fetch address, sampled with flush
- q_valid  out  1  queue non-empty
- q_data  out  DATA_W  head byte
- q_pc  out  ADDR_W  address of head byte
- q_pop  in  1  consume head byte

## Operation
- Registers: fetch_pc (next address to read), head_pc, FIFO storage, count (0..DEPTH), state.
- States: IDLE, ADDR, DATA.
  - IDLE: r=0. Go ADDR when count<DEPTH and !hold.
  - ADDR: address_bus=fetch_pc, r=1; fetch_pc+=1; go DATA unconditionally.
  - DATA: r=0; at end of cycle bus_data_in written to tail, count+=1. Go ADDR if count_next<DEPTH and !hold, else IDLE.
- At most one read in flight; a read starts only with a guaranteed free slot, so a write never finds the FIFO full.
- q_pop with q_valid: head advances, head_pc+=1, count-=1. q_pop on empty is ignored.
- Push and pop on the same edge: count unchanged, both take effect.
- flush (highest priority): count=0, head_pc=flush_pc, any DATA-state byte dropped, simultaneous q_pop ignored. Next state ADDR with fetch_pc=flush_pc (IDLE if hold). The ADDR cycle reads flush_pc, and fetch_pc becomes flush_pc+1.
- hold does not abort an ADDR/DATA pair in progress; it only blocks the next ADDR.
- fetch_pc and head_pc wrap modulo 2^ADDR_W (16'hFFFF → 16'h0000).
- Reset values: r=0, address_bus=0 (driven only in ADDR, 0 otherwise), q_valid=0, q_data=0, q_pc=RESET_PC, fetch_pc=RESET_PC, count=0, state IDLE. Assertion mid-read abandons the read immediately.

## Timing
- After reset release, edge 1 enters ADDR (r=1, address_bus=RESET_PC). Edge 2 enters DATA. Edge 3 captures, so q_valid=1 after edge 3.
- Sustained throughput: one byte per 2 cycles.
- Flush latency: flush sampled on edge N. ADDR(flush_pc) runs during N→N+1, and q_valid=1 with q_pc=flush_pc after edge N+2.
- q_data/q_pc are registered FIFO head outputs, valid in the same cycle as q_valid.

## Configuration
- CPU_PREFETCH_PAIR_EN defined: adds ports q_data1 (out, DATA_W, byte at head+1), q_valid2 (out, count≥2) and q_pop2 (in, consumes two bytes when q_valid2, head_pc+=2). q_pop2 wins over q_pop. q_pop2 with count<2 is ignored. A push on the same edge is still accepted. This supports single-cycle 16-bit operand fetch.
- Undefined: these ports do not exist and only single-byte pop is available.

## Test plan
- Reset release, memory holds 8'hA0+offset at 16'h2000.. → bytes A0,A1,A2,A3 popped in order, with q_pc 2000..2003 and the first q_valid after edge 3.
- No pops, DEPTH=4 → exactly 4 reads issued (r pulses at 2000..2003), then IDLE with r=0 and count=4. A single pop then triggers a read of 16'h2004.
- Flush to 16'h3000 while in DATA of read 16'h2002 → the 2002 byte is never visible, and q_pc=3000 becomes valid 2 edges after flush.
- hold asserted in ADDR → the current read completes, no further r pulse until hold drops, and fetch resumes at the next sequential address.
- Flush to 16'hFFFF → bytes from FFFF then 0000 are read, and q_pc wraps to 0000.
- With CPU_PREFETCH_PAIR_EN, queue holding 12,34,56: q_pop2 pops 12 and 34, the head becomes 56, q_valid2=0, and a q_pop2 at count=1 is ignored.
